// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 16-bit CPU control path.
// Contents: opcode/ext constants, FSM state encoding, next-PC and write-back
// select encodings, and the one-hot instruction class struct.
package cpu_pkg;
  localparam logic [3:0] OP_RTYPE  = 4'h0;
  localparam logic [3:0] OP_MEMJ   = 4'h4;
  localparam logic [3:0] OP_BCOND  = 4'hC;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_RD = 3'd4,
    S_MEM_WR = 3'd5,
    S_BRANCH = 3'd6
  } state_t;
  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  typedef struct packed {
    logic rtype;
    logic itype;
    logic load;
    logic stor;
    logic jcond;
    logic jal;
    logic bcond;
    logic nop;
  } iclass_t;
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational instruction-register to one-hot class decode.
// Ports: instr_i - instruction register (opcode [15:12], ext [7:4]);
//        cls_o   - exactly one class bit set.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr_i,
  output iclass_t     cls_o
);
  logic [3:0] op;
  logic [3:0] ext;
  logic       memj;
  logic       unused_bits;
  assign op          = instr_i[15:12];
  assign ext         = instr_i[7:4];
  assign memj        = op == OP_MEMJ;
  assign unused_bits = ^{instr_i[11:8], instr_i[3:0]};
  always_comb begin
    cls_o       = '0;
    cls_o.rtype = op == OP_RTYPE;
    cls_o.bcond = op == OP_BCOND;
    cls_o.itype = !(cls_o.rtype || cls_o.bcond || memj);
    cls_o.load  = memj && ext == EXT_LOAD;
    cls_o.stor  = memj && ext == EXT_STOR;
    cls_o.jal   = memj && ext == EXT_JAL;
    cls_o.jcond = memj && ext == EXT_JCOND;
    // Unrecognised ext under the memory/jump opcode just advances the PC.
    cls_o.nop   = memj && !(cls_o.load || cls_o.stor || cls_o.jal || cls_o.jcond);
  end
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch/decode/execute control FSM for the 16-bit CPU.
// Inputs:  clk, reset (async, active-high), run, instr, cond_met, mem_ready.
// Outputs: ir_load_en, mem_rd_en, mem_wr_en, addr_sel, pc_en, pc_sel,
//          rf_wr_en, rf_wr_sel, flags_en, imm_sel, state (debug).
module cpu_ctrl_fsm
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        cond_met,
  input  logic        mem_ready,
  output logic        ir_load_en,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic        addr_sel,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        rf_wr_en,
  output logic [1:0]  rf_wr_sel,
  output logic        flags_en,
  output logic        imm_sel,
  output logic [2:0]  state
);
  state_t  state_q;
  state_t  state_d;
  iclass_t cls;
  instr_class_decode u_dec (
    .instr_i(instr),
    .cls_o  (cls)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  assign state = state_q;
  // Outputs depend only on state_q plus Mealy terms, so reset clears them at once.
  always_comb begin
    state_d    = state_q;
    ir_load_en = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    addr_sel   = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = PC_INC;
    rf_wr_en   = 1'b0;
    rf_wr_sel  = WB_ALU;
    flags_en   = 1'b0;
    imm_sel    = 1'b0;
    case (state_q)
      S_IDLE: state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_rd_en  = 1'b1;
        ir_load_en = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE:
        state_d = cls.load ? S_MEM_RD :
                  cls.stor ? S_MEM_WR :
                  (cls.jcond || cls.bcond || cls.jal) ? S_BRANCH : S_EXEC;
      S_EXEC: begin
        rf_wr_en = !cls.nop;
        flags_en = cls.rtype || cls.itype;
        imm_sel  = cls.itype;
        pc_en    = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_RD: begin
        mem_rd_en = 1'b1;
        addr_sel  = 1'b1;
        rf_wr_en  = mem_ready;
        rf_wr_sel = mem_ready ? WB_MEM : WB_ALU;
        pc_en     = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_wr_en = 1'b1;
        addr_sel  = 1'b1;
        pc_en     = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        pc_en     = 1'b1;
        pc_sel    = cls.jal ? PC_REG : !cond_met ? PC_INC : cls.bcond ? PC_DISP : PC_REG;
        rf_wr_en  = cls.jal;
        rf_wr_sel = cls.jal ? WB_LINK : WB_ALU;
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: randomized scoreboard bench for cpu_ctrl_fsm.
module tb_cpu_ctrl_fsm;
  localparam int RT = 0, IT = 1, LD = 2, ST = 3, JC = 4, JL = 5, BC = 6, NP = 7;
  logic        clk = 0, reset = 1, run = 0, cond_met = 0, mem_ready = 0;
  logic [15:0] instr = 16'h0;
  logic        ir_load_en, mem_rd_en, mem_wr_en, addr_sel, pc_en, rf_wr_en, flags_en, imm_sel;
  logic [1:0]  pc_sel, rf_wr_sel;
  logic [2:0]  state;
  logic [14:0] exp_q[$];
  logic [15:0] ir_m = 16'h0;
  int          n_vec = 0, n_bad = 0;

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .cond_met(cond_met),
    .mem_ready(mem_ready), .ir_load_en(ir_load_en), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .addr_sel(addr_sel), .pc_en(pc_en), .pc_sel(pc_sel),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .flags_en(flags_en),
    .imm_sel(imm_sel), .state(state)
  );

  always #5 clk = ~clk;

  wire [14:0] got = {state, ir_load_en, mem_rd_en, mem_wr_en, addr_sel, pc_en,
                     pc_sel, rf_wr_en, rf_wr_sel, flags_en, imm_sel};

  // Expected per-cycle output vector: state, ir, rd, wr, addr, pc_en, pc_sel, rf, wb_sel, flags, imm.
  function automatic logic [14:0] v(input int st, ir, rd, wr, as, pe, ps, rf, ws, fl, im);
    return {st[2:0], ir[0], rd[0], wr[0], as[0], pe[0], ps[1:0], rf[0], ws[1:0], fl[0], im[0]};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic int cls(input logic [15:0] i);
    if (i[15:12] == 4'h0) return RT;
    if (i[15:12] == 4'hC) return BC;
    if (i[15:12] != 4'h4) return IT;
    if (i[7:4] == 4'h0) return LD;
    if (i[7:4] == 4'h4) return ST;
    if (i[7:4] == 4'h8) return JL;
    if (i[7:4] == 4'hC) return JC;
    return NP;
  endfunction

  function automatic logic [15:0] gen();
    logic [15:0] r = 16'($urandom);
    int          k = $urandom_range(0, 7);
    if (k == 0) r[15:12] = 4'h0;
    if (k == 1) r[15:12] = 4'hC;
    if (k >= 2 && k <= 6) r[15:12] = 4'h4;
    if (k == 2) r[7:4] = 4'h0;
    if (k == 3) r[7:4] = 4'h4;
    if (k == 4) r[7:4] = 4'h8;
    if (k == 5) r[7:4] = 4'hC;
    if (k == 6) begin
      r[7:4] = 4'h0;
      while (r[7:4] inside {4'h0, 4'h4, 4'h8, 4'hC}) r[7:4] = 4'($urandom);
    end
    if (k == 7) begin
      r[15:12] = 4'h0;
      while (r[15:12] inside {4'h0, 4'h4, 4'hC}) r[15:12] = 4'($urandom);
    end
    return r;
  endfunction

  task automatic cyc(input bit rs, rn, rdy, cm, input logic [15:0] ins, input logic [14:0] e);
    @(posedge clk);
    #1;
    reset = rs; run = rn; mem_ready = rdy; cond_met = cm; instr = ins;
    exp_q.push_back(e);
  endtask

  // One instruction from fetch to completion, wf/wa wait cycles on fetch/data access.
  task automatic do_instr(input logic [15:0] ins, input int wf, wa, input bit cm);
    int c = cls(ins);
    int ps;
    for (int i = 0; i < wf; i++) cyc(0, rb(), 0, rb(), ir_m, v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, rb(), 1, rb(), ir_m, v(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    ir_m = ins;
    cyc(0, rb(), rb(), rb(), ins, v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (c == LD) begin
      for (int i = 0; i < wa; i++) cyc(0, rb(), 0, rb(), ins, v(4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      cyc(0, rb(), 1, rb(), ins, v(4, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0));
    end else if (c == ST) begin
      for (int i = 0; i < wa; i++) cyc(0, rb(), 0, rb(), ins, v(5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      cyc(0, rb(), 1, rb(), ins, v(5, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    end else if (c == RT || c == IT || c == NP) begin
      cyc(0, rb(), rb(), rb(), ins,
          v(3, 0, 0, 0, 0, 1, 0, int'(c != NP), 0, int'(c != NP), int'(c == IT)));
    end else begin
      ps = (c == JL) ? 2 : !cm ? 0 : (c == BC) ? 1 : 2;
      cyc(0, rb(), rb(), cm, ins,
          v(6, 0, 0, 0, 0, 1, ps, int'(c == JL), (c == JL) ? 2 : 0, 0, 0));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (exp_q.size() != 0) begin
      logic [14:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL outvec#%0d t=%0t got=%h exp=%h (st,ir,rd,wr,as,pe,ps,rf,ws,fl,im)",
                 n_vec, $time, got, e);
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 16'h0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 1, 1, 1, 16'h0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 16'h0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 1, 16'h0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 16'h0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_instr(16'h0521, 0, 0, 0);
    do_instr(16'h4103, 0, 2, 0);
    do_instr(16'h4143, 0, 0, 0);
    do_instr(16'hC1A5, 0, 0, 0);
    do_instr(16'hC1A5, 0, 0, 1);
    do_instr(16'h4382, 0, 0, 0);
    do_instr(16'h4382, 0, 0, 1);
    do_instr(16'h40C7, 0, 0, 1);
    do_instr(16'h40C7, 0, 0, 0);
    do_instr(16'h4A33, 0, 0, 1);
    do_instr(16'h1234, 4, 0, 0);
    do_instr(16'h4143, 1, 3, 1);
    repeat (300)
      do_instr(gen(), rb() ? 0 : $urandom_range(1, 3), rb() ? 0 : $urandom_range(1, 3), rb());
    // Reset while MEM_WR is waiting on mem_ready, then idle with run low.
    cyc(0, 1, 1, 0, ir_m, v(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    ir_m = 16'h4143;
    cyc(0, 1, 0, 0, ir_m, v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, ir_m, v(5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, ir_m, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 1, 1, 1, ir_m, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) cyc(0, 0, rb(), rb(), ir_m, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, ir_m, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_instr(16'h0521, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control state machine for the 16-bit CPU. Sequences fetch, decode and execute. Drives the instruction register load enable, PC update, memory read/write strobes, register-file write enable and the datapath mux selects. Sits between unified instruction/data memory and the datapath (instruction register, PC, register file, ALU).

## Interface
Parameters:
- none; encodings come from the shared package.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- run  in  1  leave IDLE and start executing; sampled only in IDLE
- instr  in  16  instruction register output; opcode = instr[15:12], ext = instr[7:4]
- cond_met  in  1  branch condition true (from external condition checker)
- mem_ready  in  1  memory handshake done; read data valid in that same cycle
- ir_load_en  out  1  load instruction register from memory read data
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- addr_sel  out  1  memory address source: 0 = PC, 1 = register Raddr
- pc_en  out  1  update PC this cycle
- pc_sel  out  2  next-PC source: 00 = PC+1, 01 = PC+disp, 10 = register target
- rf_wr_en  out  1  register-file write
- rf_wr_sel  out  2  write-back source: 00 = ALU, 01 = memory data, 10 = PC+1 (link)
- flags_en  out  1  latch ALU flags
- imm_sel  out  1  ALU B operand: 0 = register, 1 = sign-extended immediate
- state  out  3  current state, for debug

## Operation
Instruction classes are decoded from the instruction register:
- RTYPE: opcode 0000
- LOAD: opcode 0100, ext 0000
- STOR: opcode 0100, ext 0100
- JCOND: opcode 0100, ext 1100
- JAL: opcode 0100, ext 1000
- BCOND: opcode 1100
- ITYPE: every other opcode
- Opcode 0100 with any other ext is treated as a NOP: PC+1 only.

States and transitions:
- IDLE: all outputs 0. Goes to FETCH when run=1.
- FETCH: mem_rd_en=1, addr_sel=0.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: ir_load_en=1 in that same cycle (Mealy), then DECODE.
- DECODE: all strobes 0. Next state:
  - RTYPE/ITYPE → EXEC
  - LOAD → MEM_RD
  - STOR → MEM_WR
  - JCOND/BCOND/JAL → BRANCH
  - NOP → EXEC with rf_wr_en suppressed
- EXEC: rf_wr_en=1, rf_wr_sel=00, flags_en=1, imm_sel=1 for ITYPE, pc_en=1, pc_sel=00. Then FETCH.
- MEM_RD: mem_rd_en=1, addr_sel=1.
  - When mem_ready=1: rf_wr_en=1, rf_wr_sel=01, pc_en=1, pc_sel=00 in that same cycle (Mealy), then FETCH.
  - Otherwise stays in MEM_RD.
- MEM_WR: mem_wr_en=1, addr_sel=1; held until mem_ready=1.
  - On mem_ready=1: pc_en=1, pc_sel=00, then FETCH.
- BRANCH: pc_en=1.
  - pc_sel = 01 (BCOND) or 10 (JCOND) if cond_met=1, else 00.
  - JAL: pc_sel=10 unconditionally, plus rf_wr_en=1, rf_wr_sel=10.
  - Then FETCH.

Rules:
- run is ignored outside IDLE; the machine never returns to IDLE except via reset.
- flags_en is asserted only in EXEC for RTYPE/ITYPE.
- rf_wr_en and mem_wr_en are never high in the same cycle.

## Timing
- Reset: state=IDLE and every output 0 immediately (asynchronous). Strobes drop mid-transaction; no partial write-back.
- Minimum latency with zero-wait memory (mem_ready high in the first cycle of each access): 3 cycles per instruction, for every class.
- Each wait cycle on mem_ready adds exactly 1 cycle. Strobe and address_sel stay stable while waiting.
- The memory must not see a strobe drop before mem_ready.
- The instruction register is updated at the FETCH→DECODE edge, so instr is valid throughout DECODE and later states.

## Structure
- Shared package/include `cpu_pkg`:
  - opcode and ext constants
  - state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM_RD=4, MEM_WR=5, BRANCH=6
  - pc_sel and rf_wr_sel encodings
- One natural sub-module: `instr_class_decode`, a combinational instr → class one-hot used by DECODE and the output logic.
- FSM: one sequential state register plus combinational next-state/output logic.

## Test plan
- Reset then run=1, zero-wait memory, instr=0x0521 (RTYPE): states 1,2,3,1. ir_load_en pulses in cycle 1; rf_wr_en, flags_en and pc_en high in cycle 3 with pc_sel=00.
- LOAD (0x4103) with mem_ready delayed 2 cycles in MEM_RD: mem_rd_en and addr_sel=1 held 3 cycles. rf_wr_en=1 with rf_wr_sel=01 only in the mem_ready cycle.
- STOR (0x4143) with zero-wait memory: mem_wr_en high exactly 1 cycle and rf_wr_en never high. Then BCOND (0xC1xx) with cond_met=0 gives pc_sel=00; with cond_met=1 gives pc_sel=01.
- JAL (0x4382): BRANCH asserts pc_sel=10, rf_wr_en=1, rf_wr_sel=10, regardless of cond_met.
- Assert reset during a MEM_WR wait: mem_wr_en falls in the same cycle, state=0, all outputs 0. The machine stays in IDLE until run=1.
- FETCH with mem_ready low 4 cycles: ir_load_en stays 0 until mem_ready rises, and pc_en stays 0 throughout.
